// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/ls_lane_align.sv
// Little-endian lane steering: extracts and extends a load value from a
// memory word, and merges store data into the addressed lane of that word.
module ls_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = {addr_i, 3'b000};
  assign half_sh = {addr_i[1], 4'b0000};

  // Lane extraction with sign/zero extension, and lane merge for stores.
  always_comb begin
    byte_v   = word_i[byte_sh +: 8];
    half_v   = word_i[half_sh +: 16];
    load_o   = word_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o   = unsigned_i ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merged_o = word_i;
        merged_o[byte_sh +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o   = unsigned_i ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        merged_o = word_i;
        merged_o[half_sh +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of data_mem: one request in flight, sub-word
// stores done as read-modify-write because data_mem writes whole words.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_add,
  output logic [31:0] mem_data_in,
  output logic        mem_wen,
  input  logic [31:0] mem_data_out
);

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] memdin_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merged_val;

  assign req_err = (req_size == SZ_ILL)
                 | ((req_size == SZ_HALF) && req_addr[0])
                 | ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 | (req_addr[31:2] >= MEM_LIMIT);

  ls_lane_align u_align (
    .word_i     (mem_data_out),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_val),
    .merged_o   (merged_val)
  );

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision; errors skip memory entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = ST_RESP;
          else if (!req_we)            state_d = ST_LOAD;
          else if (req_size == SZ_WORD) state_d = ST_WRITE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake and write strobe decoded from state; write blocked during reset.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !rst;
    resp_valid = (state_q == ST_RESP);
    mem_wen    = (state_q == ST_WRITE) && !rst;
  end

  // Request capture, load result and merged write word; held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      memdin_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            memdin_q <= req_wdata;
            rdata_q  <= '0;
            err_q    <= req_err;
          end
        end
        ST_LOAD:   rdata_q  <= load_val;
        ST_RMW_RD: memdin_q <= merged_val;
        default: ;
      endcase
    end
  end

  assign mem_add     = {2'b00, addr_q[31:2]};
  assign mem_data_in = memdin_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule
